kbd_event_queue: RTL and testbench

//  Memory-mapped PS/2 keyboard event controller between the PS/2 byte decoder and the CPU data bus.

---
 rtl/kbd_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/kbd_event_queue.sv | 175 +++++++++++++++++
 tb/tb_kbd_event_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event queue.
package kbd_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [1:0] {
        IDLE,
        S_E0,
        S_F0,
        S_E0F0
    } kbd_fsm_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_NUL = 8'h00;
    localparam logic [7:0] PS2_ERR = 8'hFF;

    // Register select values taken from bus_addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int DATA_VALID  = 31;
    localparam int STAT_EMPTY  = 16;
    localparam int STAT_FULL   = 17;
    localparam int STAT_OVF    = 24;
    localparam int STAT_ERR    = 25;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_DROP   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_FLUSH  = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kbd_event_queue.sv
// PS/2 prefix folding into make/break events, buffered behind DATA/STATUS/CTRL registers.
module kbd_event_queue
    import kbd_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic        cs,
    input  logic [3:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq
);

    kbd_fsm_e   state;
    kbd_fsm_e   state_nxt;
    kbd_event_t evt;
    kbd_event_t head;
    logic       evt_push;
    logic       set_err;
    logic       en;
    logic       drop_brk;
    logic       irq_en;
    logic       ovf;
    logic       err;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic [1:0] reg_sel;
    logic       ctrl_wr;
    logic       stat_wr;
    logic       flush;
    logic       pop;
    logic       push;
    logic       ovf_set;

    assign reg_sel = bus_addr[3:2];
    assign ctrl_wr = cs && bus_we && (reg_sel == REG_CTRL);
    assign stat_wr = cs && bus_we && (reg_sel == REG_STATUS);
    assign flush   = ctrl_wr && bus_wdata[CTRL_FLUSH];
    assign pop     = cs && bus_re && (reg_sel == REG_DATA) && !fifo_empty;
    assign push    = evt_push && !flush;
    assign ovf_set = push && fifo_full && !pop;
    assign irq     = irq_en && !fifo_empty;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata[31:26], bus_wdata[23:4]};

    always_comb begin
        state_nxt = state;
        evt       = '0;
        evt_push  = 1'b0;
        set_err   = 1'b0;
        if (key_valid && en) begin
            if (key_code == PS2_NUL || key_code == PS2_ERR) begin
                set_err   = 1'b1;
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_code == PS2_EXT)
                            state_nxt = S_E0;
                        else if (key_code == PS2_BRK)
                            state_nxt = S_F0;
                        else begin
                            evt      = {1'b0, 1'b0, key_code};
                            evt_push = 1'b1;
                        end
                    end
                    S_E0: begin
                        if (key_code == PS2_BRK)
                            state_nxt = S_E0F0;
                        else begin
                            evt       = {1'b0, 1'b1, key_code};
                            evt_push  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    S_F0: begin
                        evt       = {1'b1, 1'b0, key_code};
                        evt_push  = 1'b1;
                        state_nxt = IDLE;
                    end
                    S_E0F0: begin
                        evt       = {1'b1, 1'b1, key_code};
                        evt_push  = 1'b1;
                        state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
        // Break events are still decoded so the FSM stays in step with the byte stream
        if (drop_brk && evt.brk)
            evt_push = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (flush || !en)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b1;
            drop_brk <= 1'b0;
            irq_en   <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en       <= bus_wdata[CTRL_EN];
                drop_brk <= bus_wdata[CTRL_DROP];
                irq_en   <= bus_wdata[CTRL_IRQ_EN];
            end
            // A new sticky event in the same cycle as its W1C wins over the clear
            ovf <= (ovf && !(stat_wr && bus_wdata[STAT_OVF])) || ovf_set;
            err <= (err && !(stat_wr && bus_wdata[STAT_ERR])) || set_err;
        end
    end

    sync_fifo #(
        .WIDTH($bits(kbd_event_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (evt),
        .pop  (pop),
        .flush(flush),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count),
        .head (head)
    );

    always_comb begin
        bus_rdata = '0;
        if (cs) begin
            case (reg_sel)
                REG_DATA: begin
                    if (!fifo_empty)
                        bus_rdata = {1'b1, 21'b0, head.brk, head.ext, head.code};
                end
                REG_STATUS: begin
                    bus_rdata[CNT_W-1:0] = fifo_count;
                    bus_rdata[STAT_EMPTY] = fifo_empty;
                    bus_rdata[STAT_FULL]  = fifo_full;
                    bus_rdata[STAT_OVF]   = ovf;
                    bus_rdata[STAT_ERR]   = err;
                end
                REG_CTRL: begin
                    bus_rdata[CTRL_EN]     = en;
                    bus_rdata[CTRL_DROP]   = drop_brk;
                    bus_rdata[CTRL_IRQ_EN] = irq_en;
                end
                default: bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed self-checking bench for kbd_event_queue with hand-computed register values.
module tb_kbd_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        cs;
    logic [3:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    int checks = 0;
    int passes = 0;

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;

    kbd_event_queue #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .cs       (cs),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        cs = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    endtask

    task automatic readCheck(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        cs = 1'b1; bus_re = 1'b1; bus_addr = a;
        #1 d = bus_rdata;
        @(negedge clk);
        cs = 1'b0; bus_re = 1'b0;
        checkOutput(tag, d, exp);
    endtask

    task automatic peekCheck(input string tag, input logic [3:0] a, input logic [31:0] exp);
        cs = 1'b1; bus_re = 1'b0; bus_addr = a;
        #1 checkOutput(tag, bus_rdata, exp);
        cs = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; key_valid = 1'b0; key_code = '0;
        cs = 1'b0; bus_addr = '0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0;
        #1;
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_rdata_cs0", bus_rdata, 32'h0);
        peekCheck("rst_status", A_STATUS, 32'h0001_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readCheck("ctrl_default", A_CTRL, 32'h0000_0001);

        applyStimulus(8'h1C);
        readCheck("make_status", A_STATUS, 32'h0000_0001);
        readCheck("make_data", A_DATA, 32'h8000_001C);
        readCheck("pop_status", A_STATUS, 32'h0001_0000);
        readCheck("empty_data", A_DATA, 32'h0);
        readCheck("empty_nopop", A_STATUS, 32'h0001_0000);

        applyStimulus(8'hF0); applyStimulus(8'h1C);
        readCheck("brk_data", A_DATA, 32'h8000_021C);
        applyStimulus(8'hE0); applyStimulus(8'h75);
        readCheck("ext_data", A_DATA, 32'h8000_0175);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        readCheck("extbrk_data", A_DATA, 32'h8000_0375);

        for (int i = 0; i < 9; i++)
            applyStimulus(8'h10 + 8'(i));
        readCheck("full_status", A_STATUS, 32'h0102_0008);
        for (int i = 0; i < 8; i++)
            readCheck($sformatf("ovf_pop%0d", i), A_DATA, 32'h8000_0010 + 32'(i));
        readCheck("drained_status", A_STATUS, 32'h0101_0000);
        busWrite(A_STATUS, 32'h0100_0000);
        readCheck("ovf_w1c", A_STATUS, 32'h0001_0000);

        for (int i = 0; i < 8; i++)
            applyStimulus(8'h20 + 8'(i));
        @(negedge clk);
        key_valid = 1'b1; key_code = 8'h30;
        cs = 1'b1; bus_re = 1'b1; bus_addr = A_DATA;
        #1 d = bus_rdata;
        @(negedge clk);
        key_valid = 1'b0; cs = 1'b0; bus_re = 1'b0;
        checkOutput("pushpop_data", d, 32'h8000_0020);
        readCheck("pushpop_status", A_STATUS, 32'h0002_0008);
        for (int i = 0; i < 8; i++)
            readCheck($sformatf("pp_pop%0d", i), A_DATA,
                      (i < 7) ? 32'h8000_0021 + 32'(i) : 32'h8000_0030);
        readCheck("pp_empty", A_STATUS, 32'h0001_0000);

        busWrite(A_CTRL, 32'h0000_0003);
        applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
        readCheck("drop_status", A_STATUS, 32'h0000_0001);
        readCheck("drop_data", A_DATA, 32'h8000_001C);
        readCheck("drop_empty", A_STATUS, 32'h0001_0000);
        applyStimulus(8'hFF);
        readCheck("err_set", A_STATUS, 32'h0201_0000);
        busWrite(A_STATUS, 32'h0200_0000);
        readCheck("err_w1c", A_STATUS, 32'h0001_0000);

        busWrite(A_CTRL, 32'h0000_0000);
        applyStimulus(8'h1C);
        readCheck("en0_ignored", A_STATUS, 32'h0001_0000);
        busWrite(A_CTRL, 32'h0000_0001);

        applyStimulus(8'hE0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        peekCheck("midrst_status", A_STATUS, 32'h0001_0000);
        applyStimulus(8'h75);
        peekCheck("midrst_data", A_DATA, 32'h8000_0075);
        busWrite(A_CTRL, 32'h0000_0005);
        #1 checkOutput("irq_on", {31'b0, irq}, 32'h1);
        busWrite(A_CTRL, 32'h0000_000D);
        #1 checkOutput("irq_flush", {31'b0, irq}, 32'h0);
        readCheck("flush_status", A_STATUS, 32'h0001_0000);
        readCheck("flush_ctrl", A_CTRL, 32'h0000_0005);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
